resp_demux3: RTL

//  Routes the single memory read-response stream back to the unit that issued each request:
//  the I-cache refill, the D-cache refill or the uncached load path.
//  - The issuer pushes a 2-bit destination tag in order when it sends a request.
//  - Responses return in order; each response pops the oldest tag and goes to that

---
 rtl/resp_demux3.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/resp_demux3.sv
// resp_demux3: routes the in-order memory read-response stream to the unit that
// issued each request (icache refill, dcache refill or uncached load path).
// A tag FIFO records the destination of each outstanding request. A one-entry
// output register with a valid/ready handshake presents each routed word.
// Optional feature macro: RESP_DEMUX_BURST_EN. When it is defined, each tag covers
// BEATS consecutive words and out_last marks the final beat of the burst.
module resp_demux3 #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned BEATS = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_fire,
    input  logic [1:0]    req_dst,
    output logic          req_ok,
    input  logic          rsp_valid,
    input  logic [DW-1:0] rsp_data,
    output logic          rsp_ready,
    output logic [2:0]    out_valid,
    output logic [DW-1:0] out_data,
    input  logic [2:0]    out_ready,
    output logic          out_last,
    output logic          err
);

    localparam int unsigned AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || BEATS < 2) begin : g_bad_params
        $error("resp_demux3: DEPTH must be a power of 2 >= 2 and BEATS >= 2");
    end

    logic [1:0]    tag_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [2:0]    valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;
    logic          err_q, err_d;

    logic          full, empty, push, pop;
    logic          held, drain, accept, last_beat;
    logic [1:0]    head;

    // The extra pointer MSB distinguishes full from empty when the index bits match.
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign push      = req_fire & ~full;
    assign head      = tag_q[rd_ptr_q[AW-1:0]];

    assign held      = |valid_q;
    assign drain     = held & |(valid_q & out_ready);
    assign rsp_ready = ~empty & (~held | drain);
    assign accept    = rsp_valid & rsp_ready;
    assign pop       = accept & last_beat;

    assign req_ok    = ~full;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign err       = err_q;

`ifdef RESP_DEMUX_BURST_EN
    localparam int unsigned BW = $clog2(BEATS);

    logic [BW-1:0] beat_q, beat_d;
    logic          last_q, last_d;

    assign last_beat = (beat_q == BW'(BEATS - 1));
    assign out_last  = last_q;

    // Beat counter: advances on every accepted word, wraps after the final beat.
    always_comb begin
        beat_d = beat_q;
        if (accept) begin
            beat_d = last_beat ? '0 : beat_q + 1'b1;
        end
    end

    // Burst position state and the last-beat flag travelling with the held word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q <= '0;
            last_q <= 1'b0;
        end else begin
            beat_q <= beat_d;
            last_q <= last_d;
        end
    end
`else
    assign last_beat = 1'b1;
    assign out_last  = 1'b1;
`endif

    // Tag storage: written on push only; contents are meaningless while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_q[wr_ptr_q[AW-1:0]] <= req_dst;
        end
    end

    // FIFO pointers and sticky error flag next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        err_d = err_q | (req_fire & full) | (rsp_valid & empty);
    end

    // Output register next state: load on accept, clear on drain, otherwise hold.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
`ifdef RESP_DEMUX_BURST_EN
        last_d  = last_q;
`endif
        if (accept) begin
            if (head != 2'b11) begin
                valid_d = 3'b001 << head;
                data_d  = rsp_data;
`ifdef RESP_DEMUX_BURST_EN
                last_d  = last_beat;
`endif
            end else begin
                // Accept implies any held word is draining now, so nothing remains valid.
                valid_d = '0;
            end
        end else if (drain) begin
            valid_d = '0;
        end
    end

    // Main state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            valid_q  <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            err_q    <= err_d;
        end
    end

endmodule
